addr_latch_bank: RTL and testbench

Parametrised successor to the 8-bit addressable output latch in the 14500 system. It is a clocked bank of 2^ADDR_W individually addressable output bits driven from the ICU's 1-bit data path. Beyond plain latch writes, it supports per-bit toggle and timed one-shot pulse modes, a synchronous clear-all, and a registered read-back. It sits between the ICU output-address decode and the field outputs.

---
 rtl/addr_latch_bank_pkg.sv | 13 +
 rtl/addr_latch_bank_if.sv | 30 +++
 rtl/addr_latch_cell.sv | 48 ++++
 rtl/addr_latch_bank.sv | 52 +++++
 tb/tb_addr_latch_bank.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/addr_latch_bank_pkg.sv
// Shared op encoding for the addressable output latch bank.
package addr_latch_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_PULSE  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

endpackage

// File: rtl/addr_latch_bank_if.sv
// Command/status bundle between the ICU output decode and the latch bank.
interface addr_latch_bank_if #(
  parameter int ADDR_W  = 3,
  parameter int PULSE_W = 8
);

  localparam int N = 1 << ADDR_W;

  logic [ADDR_W-1:0]              addr;
  logic                           data_in;
  logic [addr_latch_pkg::OP_W-1:0] op;
  logic                           w_disable;
  logic                           clear_all;
  logic [PULSE_W-1:0]             pulse_len;
  logic                           tick;
  logic [N-1:0]                   q;
  logic                           rd_data;
  logic [N-1:0]                   pulse_active;

  modport master (
    output addr, data_in, op, w_disable, clear_all, pulse_len, tick,
    input  q, rd_data, pulse_active
  );

  modport slave (
    input  addr, data_in, op, w_disable, clear_all, pulse_len, tick,
    output q, rd_data, pulse_active
  );

endinterface

// File: rtl/addr_latch_cell.sv
// One output bit with its own one-shot pulse down-counter.
module addr_latch_cell
  import addr_latch_pkg::*;
#(
  parameter int PULSE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel,
  input  logic [OP_W-1:0]    op,
  input  logic               data_in,
  input  logic [PULSE_W-1:0] pulse_len,
  input  logic               tick,
  input  logic               clear,
  output logic               q,
  output logic               active
);

  logic [PULSE_W-1:0] cnt;

  // Priority: reset, clear, addressed op, then tick-driven countdown.
  // A zero-length PULSE is a NOP, so the countdown still applies.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (clear) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (sel && op == OP_WRITE) begin
      q   <= data_in;
      cnt <= '0;
    end else if (sel && op == OP_TOGGLE) begin
      q   <= ~q;
      cnt <= '0;
    end else if (sel && op == OP_PULSE && pulse_len != '0) begin
      q   <= 1'b1;
      cnt <= pulse_len;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - PULSE_W'(1);
      if (cnt == PULSE_W'(1)) q <= 1'b0;
    end
  end

  // Pulse in flight whenever the counter is non-zero.
  always_comb active = (cnt != '0);

endmodule

// File: rtl/addr_latch_bank.sv
// Bank of 2^ADDR_W addressable output bits with toggle, one-shot pulse,
// clear-all and a registered read-back of the addressed bit.
module addr_latch_bank
  import addr_latch_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int PULSE_W = 8
) (
  input logic               clk,
  input logic               reset,
  addr_latch_bank_if.slave  bus
);

  localparam int N = 1 << ADDR_W;

  logic [N-1:0] sel;
  logic [N-1:0] q_bits;
  logic [N-1:0] active_bits;
  logic         rd_q;

  // One-hot address decode; a write-disabled cycle selects nothing.
  always_comb begin
    sel = '0;
    if (!bus.w_disable) sel[bus.addr] = 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    addr_latch_cell #(.PULSE_W(PULSE_W)) u_cell (
      .clk       (clk),
      .reset     (reset),
      .sel       (sel[i]),
      .op        (bus.op),
      .data_in   (bus.data_in),
      .pulse_len (bus.pulse_len),
      .tick      (bus.tick),
      .clear     (bus.clear_all),
      .q         (q_bits[i]),
      .active    (active_bits[i])
    );
  end

  // Read-back samples the pre-edge bit, so a same-cycle write is not forwarded.
  always_ff @(posedge clk) begin
    if (!reset) rd_q <= 1'b0;
    else        rd_q <= q_bits[bus.addr];
  end

  assign bus.q            = q_bits;
  assign bus.pulse_active = active_bits;
  assign bus.rd_data      = rd_q;

endmodule

// File: tb/tb_addr_latch_bank.sv
// Directed bench for addr_latch_bank with hand-computed expectations.
module tb_addr_latch_bank;
  import addr_latch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  addr_latch_bank_if #(.ADDR_W(3), .PULSE_W(8)) bus ();

  addr_latch_bank #(.ADDR_W(3), .PULSE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input int a, input logic d,
                       input logic [7:0] len, input logic t);
    bus.op        = o;
    bus.addr      = 3'(a);
    bus.data_in   = d;
    bus.pulse_len = len;
    bus.tick      = t;
    cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_q(input string tag, input logic [7:0] eq, input logic [7:0] ea);
    chk({tag, " q"}, 32'(bus.q), 32'(eq));
    chk({tag, " pulse_active"}, 32'(bus.pulse_active), 32'(ea));
  endtask

  initial begin
    // Reset held with live inputs
    reset         = 1'b0;
    bus.w_disable = 1'b0;
    bus.clear_all = 1'b0;
    drive(OP_WRITE, 5, 1'b1, 8'd3, 1'b1);
    drive(OP_PULSE, 2, 1'b1, 8'd3, 1'b1);
    chk_q("reset", 8'h00, 8'h00);
    chk("reset rd_data", 32'(bus.rd_data), 0);
    reset = 1'b1;

    // Fill the bank one bit at a time
    for (int a = 0; a < 8; a++) begin
      drive(OP_WRITE, a, 1'b1, 8'd0, 1'b0);
      chk_q($sformatf("fill%0d", a), 8'((1 << (a + 1)) - 1), 8'h00);
      chk($sformatf("fill%0d rd_data", a), 32'(bus.rd_data), 0);
    end

    // Write disabled; read-back still tracks
    bus.w_disable = 1'b1;
    drive(OP_WRITE, 3, 1'b0, 8'd0, 1'b0);
    bus.w_disable = 1'b0;
    chk_q("wdis", 8'hFF, 8'h00);
    chk("wdis rd_data", 32'(bus.rd_data), 1);
    drive(OP_NOP, 3, 1'b0, 8'd0, 1'b0);
    chk("nop rd_data", 32'(bus.rd_data), 1);

    // Clear-all; rd_data from pre-edge bit 0
    bus.clear_all = 1'b1;
    drive(OP_NOP, 0, 1'b0, 8'd0, 1'b1);
    bus.clear_all = 1'b0;
    chk_q("clr1", 8'h00, 8'h00);
    chk("clr1 rd_data", 32'(bus.rd_data), 1);

    // Pulse bit 5 for 3 ticks, tick every 2nd cycle
    drive(OP_PULSE, 5, 1'b0, 8'd3, 1'b0);
    chk_q("p5 load", 8'h20, 8'h20);
    for (int k = 1; k <= 6; k++) begin
      drive(OP_NOP, 5, 1'b0, 8'd0, (k % 2) == 0);
      chk_q($sformatf("p5 c%0d", k), (k < 6) ? 8'h20 : 8'h00, (k < 6) ? 8'h20 : 8'h00);
    end

    // Retrigger bit 2 after 2 ticks: high for 6 ticks total
    drive(OP_PULSE, 2, 1'b0, 8'd4, 1'b0);
    chk_q("p2 load", 8'h04, 8'h04);
    drive(OP_NOP, 2, 1'b0, 8'd0, 1'b1);
    drive(OP_NOP, 2, 1'b0, 8'd0, 1'b1);
    drive(OP_PULSE, 2, 1'b0, 8'd4, 1'b0);
    chk_q("p2 reload", 8'h04, 8'h04);
    for (int k = 1; k <= 4; k++) begin
      drive(OP_NOP, 2, 1'b0, 8'd0, 1'b1);
      chk_q($sformatf("p2 t%0d", k), (k < 4) ? 8'h04 : 8'h00, (k < 4) ? 8'h04 : 8'h00);
    end

    // Zero-length pulse is a no-op
    drive(OP_PULSE, 2, 1'b0, 8'd0, 1'b0);
    chk_q("len0 idle", 8'h00, 8'h00);
    drive(OP_WRITE, 4, 1'b1, 8'd0, 1'b0);
    drive(OP_PULSE, 4, 1'b0, 8'd0, 1'b0);
    chk_q("len0 latched", 8'h10, 8'h00);

    // Op on addressed bit beats tick; other bits still count
    drive(OP_PULSE, 6, 1'b0, 8'd3, 1'b0);
    chk_q("p6 load", 8'h50, 8'h40);
    drive(OP_PULSE, 0, 1'b0, 8'd3, 1'b1);
    chk_q("p0 load+tick", 8'h51, 8'h41);
    drive(OP_NOP, 0, 1'b0, 8'd0, 1'b1);
    chk_q("op-win t1", 8'h51, 8'h41);
    drive(OP_NOP, 0, 1'b0, 8'd0, 1'b1);
    chk_q("op-win t2", 8'h11, 8'h01);
    drive(OP_NOP, 0, 1'b0, 8'd0, 1'b1);
    chk_q("op-win t3", 8'h10, 8'h00);

    // Toggle aborts a running pulse
    drive(OP_PULSE, 1, 1'b0, 8'd10, 1'b0);
    chk_q("p1 load", 8'h12, 8'h02);
    for (int k = 0; k < 3; k++) drive(OP_NOP, 1, 1'b0, 8'd0, 1'b1);
    drive(OP_TOGGLE, 1, 1'b0, 8'd0, 1'b1);
    chk_q("toggle abort", 8'h10, 8'h00);
    for (int k = 0; k < 12; k++) drive(OP_NOP, 1, 1'b0, 8'd0, 1'b1);
    chk_q("toggle after", 8'h10, 8'h00);

    // Write 1 aborts a running pulse and holds
    drive(OP_PULSE, 1, 1'b0, 8'd10, 1'b0);
    for (int k = 0; k < 3; k++) drive(OP_NOP, 1, 1'b0, 8'd0, 1'b1);
    drive(OP_WRITE, 1, 1'b1, 8'd0, 1'b1);
    chk_q("write abort", 8'h12, 8'h00);
    for (int k = 0; k < 12; k++) drive(OP_NOP, 1, 1'b0, 8'd0, 1'b1);
    chk_q("write after", 8'h12, 8'h00);

    // Build 0xA5 with pulses on bits 0 and 7
    bus.clear_all = 1'b1;
    drive(OP_NOP, 0, 1'b0, 8'd0, 1'b0);
    bus.clear_all = 1'b0;
    chk_q("clr2", 8'h00, 8'h00);
    drive(OP_WRITE, 2, 1'b1, 8'd0, 1'b0);
    drive(OP_WRITE, 5, 1'b1, 8'd0, 1'b0);
    drive(OP_PULSE, 0, 1'b0, 8'd5, 1'b0);
    drive(OP_PULSE, 7, 1'b0, 8'd5, 1'b0);
    chk_q("a5 setup", 8'hA5, 8'h81);

    // Clear beats a simultaneous write and tick
    bus.clear_all = 1'b1;
    drive(OP_WRITE, 2, 1'b0, 8'd0, 1'b1);
    bus.clear_all = 1'b0;
    chk_q("clr+write", 8'h00, 8'h00);
    chk("clr+write rd_data", 32'(bus.rd_data), 1);

    // Reset mid-pulse with op and tick active
    drive(OP_WRITE, 3, 1'b1, 8'd0, 1'b0);
    drive(OP_PULSE, 4, 1'b0, 8'd5, 1'b0);
    chk_q("pre-reset", 8'h18, 8'h10);
    reset = 1'b0;
    drive(OP_WRITE, 3, 1'b1, 8'd0, 1'b1);
    chk_q("reset hold1", 8'h00, 8'h00);
    chk("reset hold1 rd_data", 32'(bus.rd_data), 0);
    drive(OP_PULSE, 4, 1'b0, 8'd5, 1'b1);
    chk_q("reset hold2", 8'h00, 8'h00);
    reset = 1'b1;
    drive(OP_NOP, 4, 1'b0, 8'd0, 1'b1);
    chk_q("post-reset", 8'h00, 8'h00);
    chk("post-reset rd_data", 32'(bus.rd_data), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
